// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Control FSM for a 4-digit mm:ss stopwatch datapath and its lap memory.
//   Turns debounced start/stop, lap and clear buttons into single-cycle
//   increment/restart/trigger pulses. It divides clk down to the seconds tick,
//   runs the lap-memory write handshake and keeps the lap count and error status.
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous, active-low reset
//   btn_start  in   start/stop level; acts on its rising edge
//   btn_lap    in   lap/save level; acts on its rising edge
//   btn_clear  in   clear level; acts on its rising edge
//   mem_ack    in   lap memory accepted the write (sampled while mem_we=1)
//   increment  out  1-cycle pulse: advance the time by one second
//   restart    out  1-cycle pulse: zero the time digits
//   trigger    out  1-cycle pulse: advance the lap-memory address
//   mem_we     out  write request; held until mem_ack or timeout
//   running    out  stopwatch is counting (RUN, or a save entered from RUN)
//   lap_count  out  laps successfully written since reset
//   laps_full  out  lap_count == MAX_LAPS
//   save_err   out  sticky: a save timed out; cleared only by rst
//
// Lap-memory handshake: mem_we rises on entry to SAVE and stays high every
// cycle until the first cycle mem_ack is seen high (write accepted; the FSM
// moves to DONE and mem_we drops) or until ACK_TIMEOUT cycles have passed
// without mem_ack (write abandoned). mem_ack is ignored while mem_we is low.
module stopwatch_ctrl #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int MAX_LAPS    = 16,
    parameter int LAP_W       = 5,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_start,
    input  logic             btn_lap,
    input  logic             btn_clear,
    input  logic             mem_ack,
    output logic             increment,
    output logic             restart,
    output logic             trigger,
    output logic             mem_we,
    output logic             running,
    output logic [LAP_W-1:0] lap_count,
    output logic             laps_full,
    output logic             save_err
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0]    TIMER_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [LAP_W-1:0] LAPS_MAX   = LAP_W'(MAX_LAPS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_SAVE,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    state_t           ret_q, ret_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             pend_inc_q, pend_inc_d;
    logic             pend_clr_q, pend_clr_d;
    logic [LAP_W-1:0] lap_count_q, lap_count_d;
    logic             save_err_q, save_err_d;
    logic             increment_q, increment_d;
    logic             restart_q, restart_d;
    logic             start_prev_q, lap_prev_q, clear_prev_q;

    logic start_ev, lap_ev, clear_ev;
    logic busy, cnt_en, tick, full, leave;

    assign start_ev = btn_start & ~start_prev_q;
    assign lap_ev   = btn_lap   & ~lap_prev_q;
    assign clear_ev = btn_clear & ~clear_prev_q;

    assign busy   = (state_q == ST_SAVE) || (state_q == ST_DONE);
    // The clock keeps running through a save that was started from RUN.
    assign cnt_en = (state_q == ST_RUN) || (busy && (ret_q == ST_RUN));
    assign tick   = cnt_en && (presc_q == PRESC_LAST);
    assign full   = (lap_count_q == LAPS_MAX);

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        timer_d     = timer_q;
        pend_inc_d  = pend_inc_q;
        pend_clr_d  = pend_clr_q;
        lap_count_d = lap_count_q;
        save_err_d  = save_err_q;
        increment_d = 1'b0;
        restart_d   = 1'b0;
        leave       = 1'b0;
        presc_d     = presc_q;
        if (cnt_en) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        case (state_q)
            ST_IDLE, ST_RUN, ST_PAUSE: begin
                // Only the highest-priority event of the cycle acts; a lap
                // press that cannot be honoured still masks a start press.
                if (clear_ev) begin
                    state_d    = ST_IDLE;
                    restart_d  = 1'b1;
                    presc_d    = '0;
                    pend_inc_d = 1'b0;
                end else begin
                    if (lap_ev) begin
                        if ((state_q != ST_IDLE) && !full) begin
                            state_d = ST_SAVE;
                            ret_d   = state_q;
                            timer_d = '0;
                        end
                    end else if (start_ev) begin
                        case (state_q)
                            ST_IDLE: state_d = ST_RUN;
                            ST_RUN:  state_d = ST_PAUSE;
                            default: state_d = ST_RUN;
                        endcase
                    end
                    // A tick on the cycle that enters SAVE is deferred so the
                    // time being written stays stable during the save.
                    if (tick) begin
                        if (state_d == ST_SAVE) begin
                            pend_inc_d = 1'b1;
                        end else begin
                            increment_d = 1'b1;
                        end
                    end
                end
            end

            ST_SAVE, ST_DONE: begin
                if (clear_ev) begin
                    pend_clr_d = 1'b1;
                end
                if (tick) begin
                    pend_inc_d = 1'b1;
                end
                if (state_q == ST_SAVE) begin
                    if (mem_ack) begin
                        state_d     = ST_DONE;
                        lap_count_d = lap_count_q + LAP_W'(1);
                    end else if (timer_q == TIMER_LAST) begin
                        leave      = 1'b1;
                        save_err_d = 1'b1;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end else begin
                    leave = 1'b1;
                end
                if (leave) begin
                    // A clear raised during the save overrides both the
                    // return state and any deferred increment.
                    if (pend_clr_q || clear_ev) begin
                        state_d    = ST_IDLE;
                        restart_d  = 1'b1;
                        presc_d    = '0;
                        pend_inc_d = 1'b0;
                        pend_clr_d = 1'b0;
                    end else begin
                        state_d     = ret_q;
                        increment_d = pend_inc_q || tick;
                        pend_inc_d  = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            ret_q        <= ST_IDLE;
            presc_q      <= '0;
            timer_q      <= '0;
            pend_inc_q   <= 1'b0;
            pend_clr_q   <= 1'b0;
            lap_count_q  <= '0;
            save_err_q   <= 1'b0;
            increment_q  <= 1'b0;
            restart_q    <= 1'b0;
            start_prev_q <= 1'b0;
            lap_prev_q   <= 1'b0;
            clear_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            presc_q      <= presc_d;
            timer_q      <= timer_d;
            pend_inc_q   <= pend_inc_d;
            pend_clr_q   <= pend_clr_d;
            lap_count_q  <= lap_count_d;
            save_err_q   <= save_err_d;
            increment_q  <= increment_d;
            restart_q    <= restart_d;
            start_prev_q <= btn_start;
            lap_prev_q   <= btn_lap;
            clear_prev_q <= btn_clear;
        end
    end

    assign increment = increment_q;
    assign restart   = restart_q;
    assign trigger   = (state_q == ST_DONE);
    assign mem_we    = (state_q == ST_SAVE);
    assign running   = cnt_en;
    assign lap_count = lap_count_q;
    assign laps_full = full;
    assign save_err  = save_err_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
//   Self-checking bench for stopwatch_ctrl with a short prescaler, a small lap
//   memory and a short ack timeout. Directed scenario tasks check timing by
//   plain arithmetic; a randomized run is checked against a cycle model that
//   works on elapsed counted cycles and mode numbers.
module tb_stopwatch_ctrl;

    localparam int TICK_DIV    = 4;
    localparam int MAX_LAPS    = 2;
    localparam int LAP_W       = 5;
    localparam int ACK_TIMEOUT = 8;

    // Reference-model modes.
    localparam int MD_IDLE  = 10;
    localparam int MD_RUN   = 11;
    localparam int MD_PAUSE = 12;
    localparam int MD_SAVE  = 13;
    localparam int MD_DONE  = 14;

    logic             clk;
    logic             rst;
    logic             btn_start, btn_lap, btn_clear, mem_ack;
    logic             increment, restart, trigger, mem_we, running;
    logic [LAP_W-1:0] lap_count;
    logic             laps_full, save_err;

    int checks;
    int errors;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .MAX_LAPS    (MAX_LAPS),
        .LAP_W       (LAP_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_start (btn_start),
        .btn_lap   (btn_lap),
        .btn_clear (btn_clear),
        .mem_ack   (mem_ack),
        .increment (increment),
        .restart   (restart),
        .trigger   (trigger),
        .mem_we    (mem_we),
        .running   (running),
        .lap_count (lap_count),
        .laps_full (laps_full),
        .save_err  (save_err)
    );

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        btn_clear = 1'b0;
        mem_ack   = 1'b0;
        rst       = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic press_start();
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
    endtask

    // ---------------- reference model ----------------
    int m_mode, m_back, m_cycles, m_age, m_laps;
    bit m_owed, m_want_clr, m_err, m_inc, m_rst;
    bit m_ps, m_pl, m_pc;

    task automatic model_reset();
        m_mode = MD_IDLE;  m_back = MD_IDLE;
        m_cycles = 0;      m_age = 0;       m_laps = 0;
        m_owed = 0;        m_want_clr = 0;  m_err = 0;
        m_inc = 0;         m_rst = 0;
        m_ps = 0;          m_pl = 0;        m_pc = 0;
    endtask

    // Advances the model across one clock edge with the given input levels.
    task automatic model_step(input bit s, input bit l, input bit c, input bit a);
        bit es, el, ec, busy, counting, tick, leave;
        es = s && !m_ps;
        el = l && !m_pl;
        ec = c && !m_pc;
        m_ps = s; m_pl = l; m_pc = c;
        busy = (m_mode == MD_SAVE) || (m_mode == MD_DONE);
        counting = (m_mode == MD_RUN) || (busy && m_back == MD_RUN);
        tick = 0;
        if (counting) begin
            m_cycles++;
            tick = (m_cycles % TICK_DIV) == 0;
        end
        m_inc = 0;
        m_rst = 0;
        if (!busy) begin
            if (ec) begin
                m_mode = MD_IDLE; m_rst = 1; m_cycles = 0; m_owed = 0;
            end else begin
                if (el) begin
                    if (m_mode != MD_IDLE && m_laps < MAX_LAPS) begin
                        m_back = m_mode; m_mode = MD_SAVE; m_age = 0;
                    end
                end else if (es) begin
                    m_mode = (m_mode == MD_RUN) ? MD_PAUSE : MD_RUN;
                end
                if (tick) begin
                    if (m_mode == MD_SAVE) m_owed = 1;
                    else m_inc = 1;
                end
            end
        end else begin
            if (ec) m_want_clr = 1;
            if (tick) m_owed = 1;
            leave = 0;
            if (m_mode == MD_SAVE) begin
                if (a) begin
                    m_mode = MD_DONE; m_laps++;
                end else if (m_age == ACK_TIMEOUT - 1) begin
                    leave = 1; m_err = 1;
                end else begin
                    m_age++;
                end
            end else begin
                leave = 1;
            end
            if (leave) begin
                if (m_want_clr) begin
                    m_mode = MD_IDLE; m_rst = 1; m_cycles = 0;
                    m_owed = 0; m_want_clr = 0;
                end else begin
                    m_mode = m_back; m_inc = m_owed; m_owed = 0;
                end
            end
        end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0; mem_ack = 1'b0;
        rst = 1'b0;
        step();
        checks++; if (increment !== 1'b0) begin errors++; $display("FAIL reset_increment got=%b exp=0", increment); end
        checks++; if (restart !== 1'b0) begin errors++; $display("FAIL reset_restart got=%b exp=0", restart); end
        checks++; if (trigger !== 1'b0) begin errors++; $display("FAIL reset_trigger got=%b exp=0", trigger); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", running); end
        checks++; if (lap_count !== '0) begin errors++; $display("FAIL reset_lap_count got=%0d exp=0", lap_count); end
        checks++; if (laps_full !== 1'b0) begin errors++; $display("FAIL reset_laps_full got=%b exp=0", laps_full); end
        checks++; if (save_err !== 1'b0) begin errors++; $display("FAIL reset_save_err got=%b exp=0", save_err); end
        rst = 1'b1;
        step();
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_idle_running got=%b exp=0", running); end
    endtask

    task automatic test_run_increment();
        int first, last, cnt, bad_gap;
        apply_reset();
        press_start();
        first = -1; last = -1; cnt = 0; bad_gap = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (increment === 1'b1) begin
                if (first < 0) first = k;
                else if (k - last != TICK_DIV) bad_gap++;
                last = k;
                cnt++;
            end
        end
        // First pulse lands TICK_DIV edges after the edge that saw the press.
        checks++; if (first !== TICK_DIV) begin errors++; $display("FAIL run_first_inc got=%0d exp=%0d", first, TICK_DIV); end
        checks++; if (cnt !== 20 / TICK_DIV) begin errors++; $display("FAIL run_inc_count got=%0d exp=%0d", cnt, 20 / TICK_DIV); end
        checks++; if (bad_gap !== 0) begin errors++; $display("FAIL run_inc_spacing got=%0d exp=0", bad_gap); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_running got=%b exp=1", running); end
    endtask

    task automatic test_pause();
        int pause_inc, first;
        apply_reset();
        press_start();
        step();
        press_start();      // two counted cycles before the pause
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_running got=%b exp=0", running); end
        pause_inc = 0;
        repeat (10) begin
            step();
            if (increment === 1'b1) pause_inc++;
        end
        checks++; if (pause_inc !== 0) begin errors++; $display("FAIL pause_no_inc got=%0d exp=0", pause_inc); end
        press_start();
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL resume_running got=%b exp=1", running); end
        first = -1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (increment === 1'b1 && first < 0) first = k;
        end
        checks++; if (first !== TICK_DIV - 2) begin errors++; $display("FAIL resume_first_inc got=%0d exp=%0d", first, TICK_DIV - 2); end
    endtask

    task automatic test_lap_ack();
        int we_cnt;
        apply_reset();
        press_start();
        step();
        btn_lap = 1'b1;
        step();
        btn_lap = 1'b0;
        we_cnt = (mem_we === 1'b1) ? 1 : 0;
        repeat (2) begin
            step();
            if (mem_we === 1'b1) we_cnt++;
        end
        checks++; if (we_cnt !== 3) begin errors++; $display("FAIL lap_we_cycles got=%0d exp=3", we_cnt); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL lap_running_save got=%b exp=1", running); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        checks++; if (trigger !== 1'b1) begin errors++; $display("FAIL lap_trigger got=%b exp=1", trigger); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL lap_we_drop got=%b exp=0", mem_we); end
        checks++; if (lap_count !== 5'd1) begin errors++; $display("FAIL lap_count got=%0d exp=1", lap_count); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL lap_running_done got=%b exp=1", running); end
        step();
        checks++; if (trigger !== 1'b0) begin errors++; $display("FAIL lap_trigger_single got=%b exp=0", trigger); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL lap_running_back got=%b exp=1", running); end
    endtask

    task automatic test_tick_in_save();
        logic exp_inc;
        apply_reset();
        press_start();
        btn_lap = 1'b1;
        step();              // save starts one counted cycle after the start
        btn_lap = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) begin
                if (k == 5) mem_ack = 1'b1;
                step();
                mem_ack = 1'b0;
            end
            // Tick falls inside the save; deferred to the first cycle back
            // (edge 6), then the next regular tick four counts later.
            exp_inc = (k == 6) || (k == 6 + TICK_DIV - 2);
            checks++;
            if (increment !== exp_inc) begin
                errors++;
                $display("FAIL save_tick_inc edge=%0d got=%b exp=%b", k, increment, exp_inc);
            end
        end
    endtask

    task automatic test_timeout();
        int we_cnt, trig_cnt;
        apply_reset();
        press_start();
        btn_lap = 1'b1;
        step();
        btn_lap = 1'b0;
        checks++; if (save_err !== 1'b0) begin errors++; $display("FAIL timeout_err_early got=%b exp=0", save_err); end
        we_cnt = (mem_we === 1'b1) ? 1 : 0;
        trig_cnt = 0;
        repeat (ACK_TIMEOUT + 3) begin
            step();
            if (mem_we === 1'b1) we_cnt++;
            if (trigger === 1'b1) trig_cnt++;
        end
        checks++; if (we_cnt !== ACK_TIMEOUT) begin errors++; $display("FAIL timeout_we_cycles got=%0d exp=%0d", we_cnt, ACK_TIMEOUT); end
        checks++; if (trig_cnt !== 0) begin errors++; $display("FAIL timeout_trigger got=%0d exp=0", trig_cnt); end
        checks++; if (save_err !== 1'b1) begin errors++; $display("FAIL timeout_save_err got=%b exp=1", save_err); end
        checks++; if (lap_count !== 5'd0) begin errors++; $display("FAIL timeout_lap_count got=%0d exp=0", lap_count); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL timeout_running got=%b exp=1", running); end
    endtask

    task automatic test_laps_full_clear();
        int we_seen;
        apply_reset();
        press_start();
        mem_ack = 1'b1;
        btn_lap = 1'b1;
        step();
        btn_lap = 1'b0;
        step();
        step();
        checks++; if (lap_count !== 5'd1) begin errors++; $display("FAIL full_lap1 got=%0d exp=1", lap_count); end
        mem_ack = 1'b0;
        btn_lap = 1'b1;
        step();
        btn_lap = 1'b0;
        btn_clear = 1'b1;
        step();              // clear raised while the save is in progress
        btn_clear = 1'b0;
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL full_save_held got=%b exp=1", mem_we); end
        checks++; if (restart !== 1'b0) begin errors++; $display("FAIL full_restart_early got=%b exp=0", restart); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        checks++; if (trigger !== 1'b1) begin errors++; $display("FAIL full_trigger got=%b exp=1", trigger); end
        checks++; if (restart !== 1'b0) begin errors++; $display("FAIL full_restart_done got=%b exp=0", restart); end
        checks++; if (laps_full !== 1'b1) begin errors++; $display("FAIL full_flag got=%b exp=1", laps_full); end
        step();
        checks++; if (restart !== 1'b1) begin errors++; $display("FAIL full_restart got=%b exp=1", restart); end
        checks++; if (increment !== 1'b0) begin errors++; $display("FAIL full_inc_with_restart got=%b exp=0", increment); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL full_idle_running got=%b exp=0", running); end
        checks++; if (lap_count !== 5'd2) begin errors++; $display("FAIL full_lap_kept got=%0d exp=2", lap_count); end
        step();
        checks++; if (restart !== 1'b0) begin errors++; $display("FAIL full_restart_single got=%b exp=0", restart); end
        press_start();
        mem_ack = 1'b1;
        btn_lap = 1'b1;
        we_seen = 0;
        repeat (4) begin
            step();
            btn_lap = 1'b0;
            if (mem_we === 1'b1) we_seen++;
        end
        mem_ack = 1'b0;
        checks++; if (we_seen !== 0) begin errors++; $display("FAIL full_lap_ignored got=%0d exp=0", we_seen); end
        checks++; if (lap_count !== 5'd2) begin errors++; $display("FAIL full_lap_count got=%0d exp=2", lap_count); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL full_still_running got=%b exp=1", running); end
    endtask

    task automatic test_random();
        logic [11:0] got, exp;
        apply_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                rst = 1'b0;
                model_reset();
            end else begin
                if ($urandom_range(0, 5) == 0)  btn_start = ~btn_start;
                if ($urandom_range(0, 6) == 0)  btn_lap   = ~btn_lap;
                if ($urandom_range(0, 39) == 0) btn_clear = ~btn_clear;
                mem_ack = ($urandom_range(0, 3) == 0);
                model_step(btn_start, btn_lap, btn_clear, mem_ack);
            end
            step();
            exp = {m_inc, m_rst, (m_mode == MD_DONE), (m_mode == MD_SAVE),
                   (m_mode == MD_RUN) || ((m_mode == MD_SAVE || m_mode == MD_DONE) && m_back == MD_RUN),
                   LAP_W'(m_laps), (m_laps == MAX_LAPS), m_err};
            got = {increment, restart, trigger, mem_we, running, lap_count, laps_full, save_err};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b exp=%b (inc,rst,trg,we,run,laps,full,err)", i, got, exp);
            end
            rst = 1'b1;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0; mem_ack = 1'b0;
        test_reset();
        test_run_increment();
        test_pause();
        test_lap_ack();
        test_tick_in_save();
        test_timeout();
        test_laps_full_clear();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
